// File: rtl/jump_ctrl.sv
// Redirect controller: arbitrates interrupt vs. EXE jump redirects, offers the
// winning PC to fetch over valid/ready, then sequences the wrong-path flush.
module jump_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  jump_enable_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  int_req_i,
  input  logic [ADDR_WIDTH-1:0] int_addr_i,
  output logic                  int_ack_o,
  input  logic                  stall_mem_i,
  output logic                  redirect_valid_o,
  output logic [ADDR_WIDTH-1:0] redirect_addr_o,
  output logic                  redirect_src_o,
  input  logic                  redirect_ready_i,
  output logic                  flush_o,
  output logic [2:0]            hold_o,
  output logic                  misalign_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t                state, state_next;
  logic [3:0]            cnt, cnt_next;
  logic [ADDR_WIDTH-1:0] addr, addr_next;
  logic                  src, src_next;
  logic                  ack, ack_next;
  logic                  misalign, misalign_next;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      addr     <= '0;
      src      <= 1'b0;
      ack      <= 1'b0;
      misalign <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      addr     <= addr_next;
      src      <= src_next;
      ack      <= ack_next;
      misalign <= misalign_next;
    end
  end

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    addr_next     = addr;
    src_next      = src;
    ack_next      = 1'b0;
    misalign_next = 1'b0;
    unique case (state)
      IDLE: begin
        // Requests only arbitrate while the pipeline is moving; sources hold during stalls.
        if (!stall_mem_i) begin
          if (int_req_i) begin
            addr_next  = {int_addr_i[ADDR_WIDTH-1:1], 1'b0};
            src_next   = 1'b1;
            ack_next   = 1'b1;
            state_next = REQ;
          end else if (jump_enable_i) begin
            if (!jump_addr_i[1]) begin
              addr_next  = {jump_addr_i[ADDR_WIDTH-1:1], 1'b0};
              src_next   = 1'b0;
              state_next = REQ;
            end else begin
              misalign_next = 1'b1;
            end
          end
        end
      end
      REQ: begin
        if (redirect_ready_i) begin
          cnt_next   = CNT_LOAD;
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (cnt == 4'd0) state_next = IDLE;
        else             cnt_next   = cnt - 4'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    redirect_valid_o = (state == REQ);
    flush_o          = (state != IDLE);
    redirect_addr_o  = {addr[ADDR_WIDTH-1:1], 1'b0};
    redirect_src_o   = src;
    int_ack_o        = ack;
    misalign_o       = misalign;
    hold_o           = 3'b000;
    // IDLE hold follows the stall directly; reset forces it low regardless.
    if (!rst_i) begin
      unique case (state)
        IDLE:    hold_o = {3{stall_mem_i}};
        REQ:     hold_o = 3'b100;
        default: hold_o = 3'b000;
      endcase
    end
  end

endmodule

// File: tb/tb_jump_ctrl.sv
// Directed bench for jump_ctrl: expected output vectors are queued per step and
// compared one cycle later against the sampled DUT outputs.
module tb_jump_ctrl;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          jump_enable;
  logic [AW-1:0] jump_addr;
  logic          int_req;
  logic [AW-1:0] int_addr;
  logic          int_ack;
  logic          stall_mem;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic          redirect_src;
  logic          redirect_ready;
  logic          flush;
  logic [2:0]    hold;
  logic          misalign;

  typedef struct {
    string       tag;
    logic [39:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  jump_ctrl #(.ADDR_WIDTH(AW), .FLUSH_CYCLES(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .jump_enable_i(jump_enable), .jump_addr_i(jump_addr),
    .int_req_i(int_req), .int_addr_i(int_addr), .int_ack_o(int_ack),
    .stall_mem_i(stall_mem),
    .redirect_valid_o(redirect_valid), .redirect_addr_o(redirect_addr),
    .redirect_src_o(redirect_src), .redirect_ready_i(redirect_ready),
    .flush_o(flush), .hold_o(hold), .misalign_o(misalign)
  );

  always #5 clk = ~clk;

  // {valid, addr, src, flush, hold, ack, misalign}
  function automatic logic [39:0] E(input logic v, input logic [31:0] a, input logic s,
                                    input logic f, input logic [2:0] h, input logic k,
                                    input logic m);
    return {v, a, s, f, h, k, m};
  endfunction

  function automatic logic [39:0] observed();
    return {redirect_valid, redirect_addr, redirect_src, flush, hold, int_ack, misalign};
  endfunction

  task automatic push(input string tag, input logic [39:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  task automatic compare_front();
    exp_t        e;
    logic [39:0] obs;
    e   = exp_q.pop_front();
    obs = observed();
    vectors++;
    assert (obs === e.v) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
    end
  endtask

  task automatic step(input string tag, input logic [39:0] v);
    push(tag, v);
    @(posedge clk);
    #1;
    compare_front();
  endtask

  task automatic check_now(input string tag, input logic [39:0] v);
    push(tag, v);
    compare_front();
  endtask

  initial begin
    rst = 1'b1; jump_enable = 1'b0; jump_addr = '0; int_req = 1'b0; int_addr = '0;
    stall_mem = 1'b0; redirect_ready = 1'b1;
    #12;
    check_now("reset_state", E(0, 32'h0, 0, 0, 3'b000, 0, 0));
    stall_mem = 1'b1;
    #1;
    check_now("reset_hold", E(0, 32'h0, 0, 0, 3'b000, 0, 0));
    stall_mem = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // basic jump, ready tied high
    jump_enable = 1'b1; jump_addr = 32'h0000_0100;
    step("j100_req", E(1, 32'h100, 0, 1, 3'b100, 0, 0));
    jump_enable = 1'b0;
    step("j100_fl1", E(0, 32'h100, 0, 1, 3'b000, 0, 0));
    step("j100_fl2", E(0, 32'h100, 0, 1, 3'b000, 0, 0));
    step("j100_idle", E(0, 32'h100, 0, 0, 3'b000, 0, 0));

    // misaligned target: pulse only
    jump_enable = 1'b1; jump_addr = 32'h0000_0102;
    step("mis_pulse", E(0, 32'h100, 0, 0, 3'b000, 0, 1));
    jump_enable = 1'b0;
    step("mis_end", E(0, 32'h100, 0, 0, 3'b000, 0, 0));

    // bit 0 cleared
    jump_enable = 1'b1; jump_addr = 32'h0000_0105;
    step("j105_req", E(1, 32'h104, 0, 1, 3'b100, 0, 0));
    jump_enable = 1'b0;
    step("j105_fl1", E(0, 32'h104, 0, 1, 3'b000, 0, 0));
    step("j105_fl2", E(0, 32'h104, 0, 1, 3'b000, 0, 0));
    step("j105_idle", E(0, 32'h104, 0, 0, 3'b000, 0, 0));

    // interrupt beats simultaneous jump
    int_req = 1'b1; int_addr = 32'h8000_0000; jump_enable = 1'b1; jump_addr = 32'h0000_0200;
    step("int_req", E(1, 32'h8000_0000, 1, 1, 3'b100, 1, 0));
    int_req = 1'b0; jump_enable = 1'b0;
    step("int_fl1", E(0, 32'h8000_0000, 1, 1, 3'b000, 0, 0));
    step("int_fl2", E(0, 32'h8000_0000, 1, 1, 3'b000, 0, 0));
    step("int_idle", E(0, 32'h8000_0000, 1, 0, 3'b000, 0, 0));

    // ready low for 5 cycles, accepted in cycle 6
    redirect_ready = 1'b0; jump_enable = 1'b1; jump_addr = 32'h0000_0300;
    step("rdy_c1", E(1, 32'h300, 0, 1, 3'b100, 0, 0));
    jump_enable = 1'b0;
    for (int i = 0; i < 5; i++) step("rdy_wait", E(1, 32'h300, 0, 1, 3'b100, 0, 0));
    redirect_ready = 1'b1;
    step("rdy_fl1", E(0, 32'h300, 0, 1, 3'b000, 0, 0));
    step("rdy_fl2", E(0, 32'h300, 0, 1, 3'b000, 0, 0));
    step("rdy_idle", E(0, 32'h300, 0, 0, 3'b000, 0, 0));

    // stall blocks arbitration
    stall_mem = 1'b1; jump_enable = 1'b1; jump_addr = 32'h0000_0400;
    for (int i = 0; i < 3; i++) step("stall_hold", E(0, 32'h300, 0, 0, 3'b111, 0, 0));
    stall_mem = 1'b0;
    step("stall_req", E(1, 32'h400, 0, 1, 3'b100, 0, 0));
    jump_enable = 1'b0;
    step("stall_fl1", E(0, 32'h400, 0, 1, 3'b000, 0, 0));
    step("stall_fl2", E(0, 32'h400, 0, 1, 3'b000, 0, 0));
    step("stall_idle", E(0, 32'h400, 0, 0, 3'b000, 0, 0));

    // async reset mid-REQ
    redirect_ready = 1'b0; jump_enable = 1'b1; jump_addr = 32'h0000_0500;
    step("rq_req", E(1, 32'h500, 0, 1, 3'b100, 0, 0));
    jump_enable = 1'b0;
    #2 rst = 1'b1;
    #1 check_now("rst_mid_req", E(0, 32'h0, 0, 0, 3'b000, 0, 0));
    @(negedge clk) rst = 1'b0;
    step("rq_after", E(0, 32'h0, 0, 0, 3'b000, 0, 0));

    // async reset mid-FLUSH
    redirect_ready = 1'b1; jump_enable = 1'b1; jump_addr = 32'h0000_0600;
    step("rf_req", E(1, 32'h600, 0, 1, 3'b100, 0, 0));
    jump_enable = 1'b0;
    step("rf_fl1", E(0, 32'h600, 0, 1, 3'b000, 0, 0));
    #2 rst = 1'b1;
    #1 check_now("rst_mid_flush", E(0, 32'h0, 0, 0, 3'b000, 0, 0));
    @(negedge clk) rst = 1'b0;
    step("rf_after", E(0, 32'h0, 0, 0, 3'b000, 0, 0));

    // interrupt raised during REQ/FLUSH waits until IDLE
    jump_enable = 1'b1; jump_addr = 32'h0000_0700;
    step("ih_req", E(1, 32'h700, 0, 1, 3'b100, 0, 0));
    jump_enable = 1'b0; int_req = 1'b1; int_addr = 32'h0000_1001;
    step("ih_fl1", E(0, 32'h700, 0, 1, 3'b000, 0, 0));
    step("ih_fl2", E(0, 32'h700, 0, 1, 3'b000, 0, 0));
    step("ih_idle", E(0, 32'h700, 0, 0, 3'b000, 0, 0));
    step("ih_int", E(1, 32'h1000, 1, 1, 3'b100, 1, 0));
    int_req = 1'b0;
    step("ih_int_fl1", E(0, 32'h1000, 1, 1, 3'b000, 0, 0));

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jump_ctrl.md
# jump_ctrl

Redirect controller for the execute-stage branch/jump unit. It arbitrates between branch/jump redirect requests from EXE and interrupt redirect requests, and hands the winning target to the fetch stage over a valid/ready handshake. It sequences the flush of wrong-path instructions in IF/ID and ID/EX, and drives the pipeline hold lines. It sits between EXE, the interrupt controller, the PC/fetch unit and the pipeline registers.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of instruction addresses.
- FLUSH_CYCLES, 2, number of cycles flush_o stays asserted after the fetch handshake completes; legal range 1..15.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- jump_enable_i  in  1  EXE branch taken / JAL / JALR.
- jump_addr_i  in  ADDR_WIDTH  EXE target address.
- int_req_i  in  1  interrupt redirect request; level, held until int_ack_o.
- int_addr_i  in  ADDR_WIDTH  interrupt handler address; stable while int_req_i=1.
- int_ack_o  out  1  one-cycle pulse when an interrupt request is accepted.
- stall_mem_i  in  1  memory-stage stall; freezes the whole pipeline.
- redirect_valid_o  out  1  new PC offered to fetch.
- redirect_addr_o  out  ADDR_WIDTH  new PC; bit 0 forced to 0.
- redirect_src_o  out  1  0 = jump, 1 = interrupt; valid with redirect_valid_o.
- redirect_ready_i  in  1  fetch accepts the redirect.
- flush_o  out  1  kill IF/ID and ID/EX contents. Has priority over hold in the pipeline registers.
- hold_o  out  3  {hold_pc, hold_ifid, hold_idex}.
- misalign_o  out  1  one-cycle pulse: jump target rejected for misalignment.

## Operation
- FSM states: IDLE, REQ, FLUSH. Flush down-counter cnt is 4 bits.
- Arbitration is done only in IDLE and only when stall_mem_i=0:
  - int_req_i=1 wins over jump_enable_i. The controller latches int_addr_i, sets src=1, pulses int_ack_o on the next cycle and goes to REQ.
  - Otherwise, if jump_enable_i=1 and jump_addr_i[1]=0, it latches jump_addr_i with bit 0 cleared, sets src=0 and goes to REQ.
  - If jump_enable_i=1 and jump_addr_i[1]=1, misalign_o pulses on the next cycle and the FSM stays in IDLE; there is no redirect.
- REQ:
  - redirect_valid_o=1; redirect_addr_o and redirect_src_o hold the latched values.
  - flush_o=1, hold_o=3'b100.
  - When redirect_ready_i=1: load cnt=FLUSH_CYCLES-1 and go to FLUSH.
  - REQ waits indefinitely for ready; valid never drops without ready.
- FLUSH:
  - flush_o=1, hold_o=3'b000, redirect_valid_o=0.
  - If cnt==0 go to IDLE; else cnt decrements.
  - The counter runs regardless of stall_mem_i.
- jump_enable_i and int_req_i are ignored in REQ and FLUSH; those requests come from wrong-path instructions. A held int_req_i is serviced once the FSM is back in IDLE.
- IDLE outputs: flush_o=0, redirect_valid_o=0, hold_o={3{stall_mem_i}} (combinational).
- Reset (asynchronous, at any time including mid-REQ/FLUSH):
  - State returns to IDLE, cnt=0, latched address=0, src=0.
  - int_ack_o=0, misalign_o=0, redirect_valid_o=0, flush_o=0, hold_o=0.

## Timing
- All outputs except hold_o in IDLE are decoded from registered state (Moore). int_ack_o and misalign_o are registered pulses.
- Request sampled at edge N: redirect_valid_o, flush_o and int_ack_o are high in cycle N+1.
- Ready high in cycle N+1: flush_o stays high in cycles N+2..N+1+FLUSH_CYCLES, then IDLE. Minimum request-to-next-accept spacing is FLUSH_CYCLES+2 cycles.
- Simultaneous jump and interrupt in IDLE: the interrupt is taken and the jump is dropped.
- Request with stall_mem_i=1: nothing is latched. The request is re-evaluated on the first cycle stall_mem_i=0; EXE and the interrupt controller hold their inputs.

## Test plan
- Reset, jump_enable_i=1, jump_addr_i=0x0000_0100, ready tied 1 -> next cycle valid=1, addr=0x100, src=0, flush=1, hold=3'b100; flush_o high 3 cycles total with FLUSH_CYCLES=2; then IDLE.
- jump_addr_i=0x0000_0102 -> misalign_o single pulse, redirect_valid_o stays 0, flush_o stays 0. jump_addr_i=0x0000_0105 -> redirect_addr_o=0x104.
- int_req_i=1 (0x8000_0000) together with jump to 0x200 -> int_ack_o one pulse, redirect_addr_o=0x8000_0000, src=1; jump ignored.
- redirect_ready_i held 0 for 5 cycles -> valid and addr stable all 5 cycles, hold_o=3'b100; accepted on cycle 6, then FLUSH.
- stall_mem_i=1 with jump pending for 3 cycles -> hold_o=3'b111, no latch; stall drops -> REQ next cycle.
- rst_i asserted asynchronously mid-REQ and mid-FLUSH -> all outputs 0 immediately; FSM in IDLE after release.
